// File: rtl/propagation_controller.sv
`default_nettype none
// ============================================================================
// propagation_controller : sequential fixpoint driver for the triadic_cascade
// propagation core; PROPAGATION_TRACE_EN adds a commit trace port.  Rev 1.0
// ============================================================================
module propagation_controller #(
    parameter int MAX_ITER = 9,
    parameter int MU_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [26:0]         start_masks,
    output logic [26:0]         core_masks,
    input  logic [26:0]         core_forced_masks,
    input  logic [8:0]          core_force_valid,
    input  logic [5:0]          core_activity,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [26:0]         result_masks,
    output logic [1:0]          result_status,
    output logic [MU_WIDTH-1:0] result_mu,
    output logic [3:0]          result_iters
`ifdef PROPAGATION_TRACE_EN
    ,
    output logic                trace_valid,
    output logic [8:0]          trace_force,
    output logic [5:0]          trace_activity
`endif
);

    localparam logic [1:0] STATUS_SOLVED   = 2'b00;
    localparam logic [1:0] STATUS_STALLED  = 2'b01;
    localparam logic [1:0] STATUS_CONFLICT = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'b11;

    // Sum is wide enough for both operands so saturation is detected exactly.
    localparam int SUM_W = ((MU_WIDTH > 6) ? MU_WIDTH : 6) + 1;
    localparam logic [SUM_W-1:0] MU_MAX = {{(SUM_W-MU_WIDTH){1'b0}}, {MU_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [MU_WIDTH-1:0] mu;
    logic [MU_WIDTH-1:0] mu_next;
    logic [SUM_W-1:0]    mu_sum;
    logic [3:0]          iters;
    logic [26:0]         merged;
    logic [2:0]          lane;
    logic                conflict;
    logic                all_onehot;
    logic                commit;
    logic                finish;
    logic [1:0]          status_next;

    always_comb begin
        conflict   = 1'b0;
        all_onehot = 1'b1;
        merged     = core_masks;
        lane       = 3'b000;
        for (int i = 0; i < 9; i++) begin
            lane = core_forced_masks[3*i +: 3];
            if (lane == 3'b000) begin
                conflict = 1'b1;
            end
            if (!$onehot(core_masks[3*i +: 3])) begin
                all_onehot = 1'b0;
            end
            if (core_force_valid[i]) begin
                merged[3*i +: 3] = lane;
            end
        end
    end

    assign mu_sum  = SUM_W'(mu) + SUM_W'(core_activity);
    assign mu_next = (mu_sum > MU_MAX) ? {MU_WIDTH{1'b1}} : mu_sum[MU_WIDTH-1:0];

    always_comb begin
        state_next  = state;
        commit      = 1'b0;
        finish      = 1'b0;
        status_next = STATUS_STALLED;
        case (state)
            S_IDLE: begin
                if (start_valid) begin
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                if (conflict) begin
                    status_next = STATUS_CONFLICT;
                    finish      = 1'b1;
                end else if (core_force_valid == 9'd0) begin
                    status_next = all_onehot ? STATUS_SOLVED : STATUS_STALLED;
                    finish      = 1'b1;
                end else if (iters == 4'(MAX_ITER)) begin
                    status_next = STATUS_TIMEOUT;
                    finish      = 1'b1;
                end else begin
                    commit = 1'b1;
                end
                if (finish) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign start_ready  = (state == S_IDLE);
    assign result_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            core_masks    <= 27'd0;
            mu            <= '0;
            iters         <= 4'd0;
            result_masks  <= 27'd0;
            result_status <= STATUS_SOLVED;
            result_mu     <= '0;
            result_iters  <= 4'd0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start_valid) begin
                core_masks <= start_masks;
                mu         <= '0;
                iters      <= 4'd0;
            end
            if (commit) begin
                core_masks <= merged;
                mu         <= mu_next;
                iters      <= iters + 4'd1;
            end
            // Result reflects the masks evaluated, not any uncommitted forces.
            if (finish) begin
                result_masks  <= core_masks;
                result_status <= status_next;
                result_mu     <= mu;
                result_iters  <= iters;
            end
        end
    end

`ifdef PROPAGATION_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trace_valid    <= 1'b0;
            trace_force    <= 9'd0;
            trace_activity <= 6'd0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                trace_force    <= core_force_valid;
                trace_activity <= core_activity;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_propagation_controller.sv
`default_nettype none
// Bench for propagation_controller: a graph-based core stand-in drives two
// instances (defaults, and MAX_ITER=2 / MU_WIDTH=4) checked against a fixpoint model.
module tb_propagation_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_valid   [2];
    logic        start_ready   [2];
    logic        result_valid  [2];
    logic        result_ready  [2];
    logic [26:0] start_masks   [2];
    logic [26:0] core_masks    [2];
    logic [26:0] core_forced   [2];
    logic [26:0] result_masks  [2];
    logic [8:0]  force_valid   [2];
    logic [5:0]  activity      [2];
    logic [1:0]  result_status [2];
    logic [15:0] result_mu     [2];
    logic [3:0]  mu_small;
    logic [3:0]  result_iters  [2];
    logic [41:0] ev            [2];
`ifdef PROPAGATION_TRACE_EN
    logic        trace_valid    [2];
    logic [8:0]  trace_force    [2];
    logic [5:0]  trace_activity [2];
    logic [8:0]  tr_f [$];
    logic [5:0]  tr_a [$];
`endif

    int checks = 0;
    int errors = 0;

    // Undirected constraint graph of the stand-in core (bit j set = edge to node j).
    bit [8:0] adj [9] = '{9'b000110110, 9'b000101101, 9'b001001011,
                          9'b110000110, 9'b101100001, 9'b010010011,
                          9'b000010100, 9'b000101000, 9'b000011000};

    // Stand-in core: remove colours of one-hot neighbours; a lane is forced
    // when an undecided node is left with exactly one colour; 3 µ per force.
    function automatic logic [41:0] core_eval(input logic [26:0] m);
        logic [26:0] f;
        logic [8:0]  fv;
        logic [2:0]  ex;
        logic [2:0]  l;
        int          n;
        f = '0; fv = '0; n = 0;
        for (int i = 0; i < 9; i++) begin
            ex = 3'b000;
            for (int j = 0; j < 9; j++)
                if (adj[i][j] && $countones(m[3*j +: 3]) == 1) ex = ex | m[3*j +: 3];
            l = m[3*i +: 3] & ~ex;
            f[3*i +: 3] = l;
            if ($countones(m[3*i +: 3]) != 1 && $countones(l) == 1) begin
                fv[i] = 1'b1;
                n += 3;
            end
        end
        return {f, fv, 6'(n)};
    endfunction

    // Reference fixpoint: returns final status/masks/µ/commits and evaluation count.
    function automatic void ref_run(input logic [26:0] s, input int maxit, input int muw,
                                    output logic [1:0] st, output logic [26:0] m,
                                    output int mu, output int it, output int nev);
        logic [41:0] e;
        logic [26:0] f;
        logic [8:0]  fv;
        int          cap;
        bit          conf;
        bit          allone;
        cap = (1 << muw) - 1;
        m = s; mu = 0; it = 0; nev = 0; st = 2'b01;
        for (int k = 0; k < 40; k++) begin
            nev++;
            e  = core_eval(m);
            f  = e[41:15];
            fv = e[14:6];
            conf = 0; allone = 1;
            for (int i = 0; i < 9; i++) begin
                if (f[3*i +: 3] == 3'b000) conf = 1;
                if ($countones(m[3*i +: 3]) != 1) allone = 0;
            end
            if (conf) begin st = 2'b10; return; end
            if (fv == 9'd0) begin st = allone ? 2'b00 : 2'b01; return; end
            if (it == maxit) begin st = 2'b11; return; end
            for (int i = 0; i < 9; i++)
                if (fv[i]) m[3*i +: 3] = f[3*i +: 3];
            mu = (mu + int'(e[5:0]) > cap) ? cap : mu + int'(e[5:0]);
            it++;
        end
    endfunction

    assign ev[0] = core_eval(core_masks[0]);
    assign ev[1] = core_eval(core_masks[1]);
    assign core_forced[0] = ev[0][41:15];
    assign force_valid[0] = ev[0][14:6];
    assign activity[0]    = ev[0][5:0];
    assign core_forced[1] = ev[1][41:15];
    assign force_valid[1] = ev[1][14:6];
    assign activity[1]    = ev[1][5:0];
    assign result_mu[1]   = {12'd0, mu_small};

    propagation_controller #(.MAX_ITER(9), .MU_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid[0]), .start_ready(start_ready[0]), .start_masks(start_masks[0]),
        .core_masks(core_masks[0]), .core_forced_masks(core_forced[0]),
        .core_force_valid(force_valid[0]), .core_activity(activity[0]),
        .result_valid(result_valid[0]), .result_ready(result_ready[0]),
        .result_masks(result_masks[0]), .result_status(result_status[0]),
        .result_mu(result_mu[0]), .result_iters(result_iters[0])
`ifdef PROPAGATION_TRACE_EN
        , .trace_valid(trace_valid[0]), .trace_force(trace_force[0]),
        .trace_activity(trace_activity[0])
`endif
    );

    propagation_controller #(.MAX_ITER(2), .MU_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid[1]), .start_ready(start_ready[1]), .start_masks(start_masks[1]),
        .core_masks(core_masks[1]), .core_forced_masks(core_forced[1]),
        .core_force_valid(force_valid[1]), .core_activity(activity[1]),
        .result_valid(result_valid[1]), .result_ready(result_ready[1]),
        .result_masks(result_masks[1]), .result_status(result_status[1]),
        .result_mu(mu_small), .result_iters(result_iters[1])
`ifdef PROPAGATION_TRACE_EN
        , .trace_valid(trace_valid[1]), .trace_force(trace_force[1]),
        .trace_activity(trace_activity[1])
`endif
    );

`ifdef PROPAGATION_TRACE_EN
    always @(negedge clk) begin
        if (trace_valid[0]) begin
            tr_f.push_back(trace_force[0]);
            tr_a.push_back(trace_activity[0]);
        end
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input int d);
        check("rst_start_ready", 32'(start_ready[d]), 1);
        check("rst_result_valid", 32'(result_valid[d]), 0);
        check("rst_core_masks", 32'(core_masks[d]), 0);
        check("rst_result_masks", 32'(result_masks[d]), 0);
        check("rst_status", 32'(result_status[d]), 0);
        check("rst_mu", 32'(result_mu[d]), 0);
        check("rst_iters", 32'(result_iters[d]), 0);
    endtask

    // One start-to-release transaction, checking the DUT every cycle.
    task automatic transact(input int d, input logic [26:0] m, input int hold, input bit noise);
        logic [1:0]  est;
        logic [26:0] em;
        int          emu, eit, nev, cyc;
        ref_run(m, (d == 0) ? 9 : 2, (d == 0) ? 16 : 4, est, em, emu, eit, nev);
        @(negedge clk);
        check("start_ready_idle", 32'(start_ready[d]), 1);
        start_valid[d]  = 1'b1;
        start_masks[d]  = m;
        result_ready[d] = 1'b0;
        @(negedge clk);
        cyc = 1;
        start_valid[d] = noise;
        start_masks[d] = 27'($urandom);
        while (!result_valid[d] && cyc < 40) begin
            check("start_ready_busy", 32'(start_ready[d]), 0);
            @(negedge clk);
            cyc++;
        end
        start_valid[d] = 1'b0;
        check("latency", 32'(cyc), 32'(nev + 1));
        check("status", 32'(result_status[d]), 32'(est));
        check("masks", 32'(result_masks[d]), 32'(em));
        check("mu", 32'(result_mu[d]), 32'(emu));
        check("iters", 32'(result_iters[d]), 32'(eit));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(result_valid[d]), 1);
            check("hold_ready", 32'(start_ready[d]), 0);
            check("hold_masks", 32'(result_masks[d]), 32'(em));
            check("hold_mu", 32'(result_mu[d]), 32'(emu));
        end
        result_ready[d] = 1'b1;
        @(negedge clk);
        result_ready[d] = 1'b0;
        check("release_valid", 32'(result_valid[d]), 0);
        check("release_ready", 32'(start_ready[d]), 1);
    endtask

    function automatic logic [26:0] rand_masks();
        logic [26:0] v;
        int          r;
        for (int i = 0; i < 9; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      v[3*i +: 3] = 3'b111;
            else if (r < 9) v[3*i +: 3] = 3'b001 << $urandom_range(0, 2);
            else            v[3*i +: 3] = 3'($urandom_range(0, 7));
        end
        return v;
    endfunction

    localparam logic [26:0] CASCADE  = 27'b111_111_111_111_111_111_111_010_001;
    localparam logic [26:0] CONFL    = 27'b111_111_111_111_111_111_111_001_001;
    localparam logic [26:0] ALL_FREE = 27'b111_111_111_111_111_111_111_111_111;
    localparam logic [26:0] SOLVED_M = 27'b100_010_001_100_010_001_100_010_001;
    localparam logic [26:0] TIMEO_M  = 27'b111_111_111_100_010_001_100_010_001;

    initial begin
        logic [1:0]  st;
        logic [26:0] mm;
        int          mu, it, nev;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_valid[d] = 1'b0; result_ready[d] = 1'b0; start_masks[d] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;

        // Hand-computed pins for the model itself.
        ref_run(CASCADE, 9, 16, st, mm, mu, it, nev);
        check("model_solved_status", 32'(st), 0);
        check("model_solved_mu", 32'(mu), 21);
        check("model_solved_iters", 32'(it), 3);
        check("model_solved_latency", 32'(nev + 1), 5);
        check("model_solved_masks", 32'(mm), 32'(SOLVED_M));
        ref_run(CASCADE, 2, 4, st, mm, mu, it, nev);
        check("model_timeout_status", 32'(st), 3);
        check("model_timeout_mu", 32'(mu), 12);
        check("model_timeout_masks", 32'(mm), 32'(TIMEO_M));
        ref_run(CONFL, 9, 16, st, mm, mu, it, nev);
        check("model_conflict_status", 32'(st), 2);
        check("model_conflict_masks", 32'(mm), 32'(CONFL));
        ref_run(ALL_FREE, 9, 16, st, mm, mu, it, nev);
        check("model_stall_status", 32'(st), 1);

`ifdef PROPAGATION_TRACE_EN
        tr_f.delete();
        tr_a.delete();
`endif
        transact(0, CASCADE, 10, 1'b0);
`ifdef PROPAGATION_TRACE_EN
        check("trace_count", 32'(tr_f.size()), 3);
        if (tr_f.size() == 3) begin
            check("trace_force0", 32'(tr_f[0]), 32'h024);
            check("trace_force1", 32'(tr_f[1]), 32'h018);
            check("trace_force2", 32'(tr_f[2]), 32'h1C0);
            check("trace_act0", 32'(tr_a[0]), 6);
            check("trace_act1", 32'(tr_a[1]), 6);
            check("trace_act2", 32'(tr_a[2]), 9);
        end
`endif
        transact(0, CONFL, 1, 1'b1);
        transact(0, ALL_FREE, 0, 1'b0);
        transact(1, CASCADE, 2, 1'b1);
        transact(0, {rand_masks()[26:3], 3'b000}, 0, 1'b0);

        for (int n = 0; n < 40; n++)
            transact(n % 2, rand_masks(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        // Reset while evaluating discards the work in progress.
        @(negedge clk);
        start_valid[0] = 1'b1;
        start_masks[0] = CASCADE;
        @(negedge clk);
        start_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset(0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_reset_valid", 32'(result_valid[0]), 0);
        end
        transact(0, CASCADE, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/propagation_controller.md
Name: propagation_controller

Overview:
- Sequential fixpoint driver for the triadic_cascade 3-colouring engine, placed directly downstream of the combinational propagation core.
- Accepts an initial 9-node mask snapshot and drives it to the core each cycle. Commits the core's forced lanes, repeating until no new forces, a conflict, or an iteration limit.
- Accumulates the µ-cost reported by the core and returns the final masks, a status code and the µ total to the sequential host.

Parameters:
- MAX_ITER, 9, maximum number of committing evaluations before TIMEOUT (1..15).
- MU_WIDTH, 16, width of the saturating µ accumulator.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start_valid  in  1  initial snapshot offered
- start_ready  out  1  controller idle, can accept
- start_masks  in  27  initial masks; node i at [3i+2:3i]
- core_masks  out  27  current registered masks, to core node_masks
- core_forced_masks  in  27  from core forced_masks
- core_force_valid  in  9  from core force_valid
- core_activity  in  6  from core activity_count
- result_valid  out  1  result held until accepted
- result_ready  in  1  host accepts result
- result_masks  out  27  final masks
- result_status  out  2  00 SOLVED, 01 STALLED, 10 CONFLICT, 11 TIMEOUT
- result_mu  out  MU_WIDTH  accumulated µ-cost
- result_iters  out  4  number of committing evaluations

Behaviour:
- Interface: one clock, clk; synchronous active-low reset, rst_n.
- Reset (rst_n low at a clock edge, including mid-operation) sets the state to IDLE. start_ready=1, result_valid=0, core_masks=0, result_masks=0, result_status=00, result_mu=0, result_iters=0. Any work in progress is discarded.
- State machine: IDLE -> EVAL -> DONE -> IDLE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: register start_masks into the mask register (core_masks), clear µ and the iteration counter, go to EVAL.
- EVAL (one core evaluation per cycle; the core is combinational on core_masks). Conditions are checked in this priority order:
  1. Conflict if any lane of core_forced_masks==000. Status CONFLICT; forces not committed; µ unchanged.
  2. Otherwise, no force if core_force_valid==0. Status SOLVED if every mask is one-hot, else STALLED.
  3. Otherwise, force with iteration count==MAX_ITER. Status TIMEOUT; not committed.
  4. Otherwise, commit: each lane i with core_force_valid[i]=1 is replaced by its core_forced_masks lane; other lanes are unchanged. µ += core_activity, saturating at 2^MU_WIDTH-1. Iteration count += 1. Stay in EVAL.
  - Cases 1–3 go to DONE and latch result_masks=current masks, status, µ and iterations.
- DONE:
  - result_valid=1; result fields stable until result_valid&&result_ready, then go to IDLE.
  - start_ready=0 in EVAL and DONE.
- Latency: with N evaluations (N-1 commits plus one terminating), result_valid rises N+1 cycles after the start handshake cycle.
- A mask of 000 in start_masks is reported as CONFLICT on the first evaluation, because the core returns lane 000.
- start_valid while busy is ignored (no accept). A start_valid asserted in the cycle DONE returns to IDLE is accepted one cycle later, in IDLE.

Optional Feature:
- Macro: PROPAGATION_TRACE_EN.
- When defined, three extra output ports are added:
  - trace_valid (1): one-cycle pulse for each committing evaluation.
  - trace_force (9): the core_force_valid value committed.
  - trace_activity (6): the core_activity value committed.
  - All three reset to 0 and are registered, appearing the cycle after the commit.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Solved cascade: start_masks node0=001, node1=010, all others 111 (MAX_ITER=9). Commits {2,5}->100 (µ+6), {3}->001, {4}->010 (µ+6), {6}->001, {7}->010, {8}->100 (µ+9), then a no-force evaluation. Required: SOLVED, result_mu=21, result_iters=3, result_valid 5 cycles after the handshake.
- Conflict: node0=001, node1=001, others 111. Required: CONFLICT, result_mu=0, result_iters=0, result_masks equal to the input.
- Stall: all nodes 111. Required: STALLED, result_mu=0, result_iters=0.
- Timeout: the solved-cascade stimulus with MAX_ITER=2. Required: TIMEOUT, result_mu=12, result_iters=2, nodes 6/7/8 still 111.
- Handshake/reset:
  - Hold result_ready=0 for 10 cycles: result stable, start_ready=0.
  - Then pulse result_ready: start_ready=1 next cycle.
  - rst_n=0 during EVAL: all outputs at reset values next cycle, no result_valid.
- Trace (PROPAGATION_TRACE_EN defined): solved cascade produces exactly 3 trace_valid pulses, with trace_force=0x024, 0x018, 0x1C0 and trace_activity=6, 6, 9.
